// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered 1-cycle instruction decode with RUN/STALL/HALT FSM; define CTRL_ILLEGAL_TRAP_EN to halt on illegal encodings
module ctrl_decode_stage #(
  parameter int INSTR_W   = 16,
  parameter int STALL_MAX = 15
) (
  input  logic               CLOCK,
  input  logic               in_rst_n,
  input  logic [INSTR_W-1:0] in_buf,
  input  logic               in_valid,
  input  logic               in_hz,
  input  logic               in_flush,
  output logic [1:0]         out_reg_write,
  output logic               out_pc_src,
  output logic               out_and,
  output logic [INSTR_W-1:0] out_ex,
  output logic               out_valid,
  output logic               out_halt,
  output logic               out_illegal,
  output logic               out_stall_to
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;
  localparam logic [7:0] SMAX = 8'(STALL_MAX);
  state_t state_q, state_d;
  logic [1:0] reg_write_q, reg_write_d;
  logic pc_src_q, pc_src_d, and_q, and_d, valid_q, valid_d;
  logic illegal_q, illegal_d, stall_to_q, stall_to_d;
  logic [INSTR_W-1:0] ex_q, ex_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] op, fn;
  logic is_alu, is_ld, is_st, is_br, is_jmp, is_hlt, legal;
  logic live, hold, dec, dec_ok, trap;
  assign op = in_buf[INSTR_W-1 -: 4];
  assign fn = in_buf[3:0];
  assign is_alu = op == 4'h0 && (fn <= 4'd5 || (fn >= 4'd8 && fn <= 4'd11));
  assign is_ld  = op == 4'hC;
  assign is_st  = op == 4'h8;
  assign is_br  = (op == 4'h4 || op == 4'h5 || op == 4'h6) && fn == 4'h0;
  assign is_jmp = op == 4'hB && fn == 4'h0;
  assign is_hlt = op == 4'hF && fn == 4'h0;
  assign legal  = is_alu | is_ld | is_st | is_br | is_jmp | is_hlt;
  // flush beats hazard beats decode; HALT ignores every request
  assign live   = state_q != HALT;
  assign hold   = live & ~in_flush & in_hz;
  assign dec    = live & ~in_flush & ~in_hz & in_valid;
  assign dec_ok = dec & legal;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = dec & ~legal;
`else
  assign trap = 1'b0;
`endif
  // state register
  always_ff @(posedge CLOCK or negedge in_rst_n)
    if (!in_rst_n) state_q <= RUN;
    else state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = !live ? HALT :
              in_flush ? RUN :
              in_hz ? STALL :
              (dec_ok & is_hlt) | trap ? HALT : RUN;
  end
  // decoded outputs; a hazard freezes everything except the illegal pulse
  always_comb begin
    reg_write_d = hold ? reg_write_q : !dec_ok ? 2'b10 : is_alu ? 2'b00 : is_ld ? 2'b01 : is_br ? 2'b11 : 2'b10;
    pc_src_d    = hold ? pc_src_q : dec_ok & (is_br | is_jmp);
    and_d       = hold ? and_q : dec_ok & (is_br | is_jmp);
    ex_d        = hold ? ex_q : dec_ok & (is_alu | is_ld | is_st | is_br) ? in_buf : '0;
    valid_d     = hold ? valid_q : dec_ok;
    illegal_d   = dec & ~legal;
    cnt_d       = (state_q == STALL && hold) ? (cnt_q == SMAX ? cnt_q : cnt_q + 8'd1) : 8'd0;
    stall_to_d  = stall_to_q | (cnt_d == SMAX);
  end
  // output and counter registers
  always_ff @(posedge CLOCK or negedge in_rst_n)
    if (!in_rst_n) begin
      reg_write_q <= 2'b10;
      pc_src_q    <= 1'b0;
      and_q       <= 1'b0;
      ex_q        <= '0;
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
      stall_to_q  <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      reg_write_q <= reg_write_d;
      pc_src_q    <= pc_src_d;
      and_q       <= and_d;
      ex_q        <= ex_d;
      valid_q     <= valid_d;
      illegal_q   <= illegal_d;
      stall_to_q  <= stall_to_d;
      cnt_q       <= cnt_d;
    end
  assign out_reg_write = reg_write_q;
  assign out_pc_src    = pc_src_q;
  assign out_and       = and_q;
  assign out_ex        = ex_q;
  assign out_valid     = valid_q;
  assign out_halt      = state_q == HALT;
  assign out_illegal   = illegal_q;
  assign out_stall_to  = stall_to_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: scoreboard bench for ctrl_decode_stage (second instance uses STALL_MAX=2)
module tb_ctrl_decode_stage;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct {
    logic [1:0]  rw;
    logic        pc;
    logic        an;
    logic [15:0] ex;
    logic        vl;
    logic        ht;
    logic        il;
  } exp_t;
  logic CLOCK = 1'b0, in_rst_n = 1'b1;
  logic [15:0] in_buf = '0;
  logic in_valid = 1'b0, in_hz = 1'b0, in_flush = 1'b0;
  logic [1:0] rw, rw2;
  logic pc, an, vl, ht, il, to, pc2, an2, vl2, ht2, il2, to2;
  logic [15:0] ex, ex2;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  ctrl_decode_stage dut (
    .CLOCK(CLOCK), .in_rst_n(in_rst_n), .in_buf(in_buf), .in_valid(in_valid),
    .in_hz(in_hz), .in_flush(in_flush), .out_reg_write(rw), .out_pc_src(pc),
    .out_and(an), .out_ex(ex), .out_valid(vl), .out_halt(ht),
    .out_illegal(il), .out_stall_to(to)
  );
  ctrl_decode_stage #(.STALL_MAX(2)) dut2 (
    .CLOCK(CLOCK), .in_rst_n(in_rst_n), .in_buf(in_buf), .in_valid(in_valid),
    .in_hz(in_hz), .in_flush(in_flush), .out_reg_write(rw2), .out_pc_src(pc2),
    .out_and(an2), .out_ex(ex2), .out_valid(vl2), .out_halt(ht2),
    .out_illegal(il2), .out_stall_to(to2)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  function automatic exp_t e(input logic [1:0] r, input logic p, input logic a,
                             input logic [15:0] x, input logic v, input logic h, input logic i);
    e = '{r, p, a, x, v, h, i};
  endfunction
  task automatic step(input string tag, input logic [15:0] ib, input logic v,
                      input logic hz, input logic fl, input exp_t want);
    exp_t w;
    in_buf = ib; in_valid = v; in_hz = hz; in_flush = fl;
    sb.push_back(want);
    @(posedge CLOCK); #1;
    w = sb.pop_front();
    chk({tag, ".rw"}, 32'(rw), 32'(w.rw));
    chk({tag, ".pc"}, 32'(pc), 32'(w.pc));
    chk({tag, ".and"}, 32'(an), 32'(w.an));
    chk({tag, ".ex"}, 32'(ex), 32'(w.ex));
    chk({tag, ".valid"}, 32'(vl), 32'(w.vl));
    chk({tag, ".halt"}, 32'(ht), 32'(w.ht));
    chk({tag, ".illegal"}, 32'(il), 32'(w.il));
    chk({tag, ".stall_to"}, 32'(to), 32'd0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".rw"}, 32'(rw), 32'd2);
    chk({tag, ".pc"}, 32'(pc), 32'd0);
    chk({tag, ".and"}, 32'(an), 32'd0);
    chk({tag, ".ex"}, 32'(ex), 32'd0);
    chk({tag, ".valid"}, 32'(vl), 32'd0);
    chk({tag, ".halt"}, 32'(ht), 32'd0);
    chk({tag, ".illegal"}, 32'(il), 32'd0);
    chk({tag, ".stall_to"}, 32'(to), 32'd0);
    chk({tag, ".stall_to2"}, 32'(to2), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #2 in_rst_n = 1'b0;
    #1 chk_reset("rst");
    @(posedge CLOCK); #1;
    in_rst_n = 1'b1;
    step("alu",    16'h0230, 1, 0, 0, e(2'b00, 0, 0, 16'h0230, 1, 0, 0));
    step("br",     16'h4120, 1, 0, 0, e(2'b11, 1, 1, 16'h4120, 1, 0, 0));
    step("jmp",    16'hB000, 1, 0, 0, e(2'b10, 1, 1, 16'h0000, 1, 0, 0));
    step("st",     16'h8ABC, 1, 0, 0, e(2'b10, 0, 0, 16'h8ABC, 1, 0, 0));
    step("ld",     16'hC345, 1, 0, 0, e(2'b01, 0, 0, 16'hC345, 1, 0, 0));
    step("stall1", 16'h0231, 1, 1, 0, e(2'b01, 0, 0, 16'hC345, 1, 0, 0));
    step("stall2", 16'h0231, 1, 1, 0, e(2'b01, 0, 0, 16'hC345, 1, 0, 0));
    step("stall3", 16'h0231, 1, 1, 0, e(2'b01, 0, 0, 16'hC345, 1, 0, 0));
    chk("to2_set", 32'(to2), 32'd1);
    step("resume", 16'h0231, 1, 0, 0, e(2'b00, 0, 0, 16'h0231, 1, 0, 0));
    chk("to2_sticky", 32'(to2), 32'd1);
    step("novalid", 16'h0230, 0, 0, 0, e(2'b10, 0, 0, 16'h0000, 0, 0, 0));
    step("hz_hold", 16'h0230, 1, 1, 0, e(2'b10, 0, 0, 16'h0000, 0, 0, 0));
    step("hz_flush", 16'h0230, 1, 1, 1, e(2'b10, 0, 0, 16'h0000, 0, 0, 0));
    step("post_flush", 16'h0230, 1, 0, 0, e(2'b00, 0, 0, 16'h0230, 1, 0, 0));
    step("run_flush", 16'h4120, 1, 0, 1, e(2'b10, 0, 0, 16'h0000, 0, 0, 0));
    step("illegal", 16'h0007, 1, 0, 0, e(2'b10, 0, 0, 16'h0000, 0, TRAP, 1));
    step("post_ill", 16'h0230, 1, 0, 0,
         e(TRAP ? 2'b10 : 2'b00, 0, 0, TRAP ? 16'h0000 : 16'h0230, !TRAP, TRAP, 0));
    step("halt",   16'hF000, 1, 0, 0, e(2'b10, 0, 0, 16'h0000, !TRAP, 1, 0));
    step("h_ign",  16'h0230, 1, 0, 0, e(2'b10, 0, 0, 16'h0000, 0, 1, 0));
    step("h_ign2", 16'h4120, 1, 1, 1, e(2'b10, 0, 0, 16'h0000, 0, 1, 0));
    #2 in_rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(posedge CLOCK); #1;
    chk_reset("rst_held");
    in_rst_n = 1'b1;
    step("after_rst", 16'h0230, 1, 0, 0, e(2'b00, 0, 0, 16'h0230, 1, 0, 0));
    step("stallA", 16'hC345, 1, 1, 0, e(2'b00, 0, 0, 16'h0230, 1, 0, 0));
    step("stallB", 16'hC345, 1, 1, 0, e(2'b00, 0, 0, 16'h0230, 1, 0, 0));
    #2 in_rst_n = 1'b0;
    #1 chk_reset("stall_rst");
    @(posedge CLOCK); #1;
    in_rst_n = 1'b1;
    step("rst_dec", 16'hC345, 1, 0, 0, e(2'b01, 0, 0, 16'hC345, 1, 0, 0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
